rib_xbar: RTL and testbench
===========================

# rib_xbar

Parametrised successor to the fixed 6-master/6-slave RIB interconnect for the dual-core TEE SoC. Arbitrates N masters (core data ports, core fetch ports, JTAG DMs) onto one shared single-cycle bus with per-master hold. Arbitration is priority-class plus round-robin, replacing fixed priority. Decodes M slaves by address, and optionally enforces a per-slave master access list with a sticky violation record.

## Interface
- `NUM_MASTERS`, 6: number of masters, 2..16.
- `NUM_SLAVES`, 6: number of slaves, 1..16. Slave index is `addr[31:28]`.
- `PRIO_MASK`, 6'b100100: masters in the high-priority class (JTAG by default).
- `SLAVE_ACL`, all ones: width NUM_SLAVES*NUM_MASTERS. Bit `[s*NUM_MASTERS+m]`=1 permits master m to access slave s.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-low.
- `m_addr_i` in NUM_MASTERS*32: per-master address, master m at `[m*32+:32]`.
- `m_data_i` in NUM_MASTERS*32: per-master write data.
- `m_we_i` in NUM_MASTERS: write enable.
- `m_req_i` in NUM_MASTERS: request.
- `m_data_o` out NUM_MASTERS*32: read data. The same word is broadcast to all masters.
- `m_hold_o` out NUM_MASTERS: the master is requesting but not granted.
- `hold_flag_o` out 1: OR of `m_hold_o`.
- `s_addr_o` out 32: `{4'h0, addr[27:0]}` of the granted master.
- `s_data_o` out 32: write data of the granted master.
- `s_we_o` out NUM_SLAVES: one-hot write strobe.
- `s_data_i` in NUM_SLAVES*32: per-slave read data.
- `err_clr_i` in 1: clears the error record.
- `err_valid_o` out 1: sticky error flag.
- `err_master_o` out 4: master index of the first error.
- `err_addr_o` out 32: full address of the first error.
- `err_cnt_o` out 8: saturating error count.

## Operation
- **Priority class:** if any requester is in `PRIO_MASK`, only those requesters compete.
- **Round-robin:** within the competing set, grant goes to the first requester at index ≥ `rr_ptr`, wrapping modulo NUM_MASTERS.
  - `rr_ptr` is a register, updated to `(g+1) mod NUM_MASTERS` on every cycle with a grant g.
  - One shared `rr_ptr` serves both classes.
- **Hold:** `m_hold_o[m] = m_req_i[m] & ~gnt[m]`. At most one grant per cycle; no grant when there is no request.
- **Decode:** `sidx = addr[31:28]` of the granted master.
  - `sidx >= NUM_SLAVES` is unmapped: read returns 32'h0, write dropped, error raised.
- **Transfer:** a write drives `s_we_o[sidx]=1` for exactly the grant cycle. A read returns `s_data_i[sidx]` on `m_data_o`.
- **Idle/drive:** with no grant, `s_we_o=0`, `s_addr_o=0`, `s_data_o=0`, `m_data_o=0`.
- **Error record:**
  - On an error with `err_valid_o=0`: capture master and address, set `err_valid_o`.
  - On an error with `err_valid_o=1`: master/address are kept.
  - `err_cnt_o` increments on every error and saturates at 255.
  - `err_clr_i` zeroes all error fields. If clear and a new error coincide, the new error is captured and count=1.

## Timing
- Address/data paths are combinational: grant, slave strobe and read data all fall in the same cycle as the request.
- Registered state: `rr_ptr` and the error record only; both update on the `clk` edge.
- Reset (async assert, sync release) sets `rr_ptr=0`, `err_valid_o=0`, `err_master_o=0`, `err_addr_o=0`, `err_cnt_o=0`.
- All combinational outputs under reset follow the grant logic with `rr_ptr=0`.
  - Masters may not rely on writes during reset; slaves are reset by the same `rst`.
- A request held continuously is granted within NUM_MASTERS cycles, provided no priority-class master requests continuously.
- A master must hold address, data and we stable while `m_hold_o` is high.

## Configuration
- `RIB_ACL_EN` defined: an access by master m to mapped slave s with ACL bit 0 is denied.
  - Denied write: `s_we_o` stays 0.
  - Denied read: returns 32'h0.
  - Records an error exactly as unmapped.
  - The grant and `rr_ptr` advance normally.
- Undefined: `SLAVE_ACL` is ignored; only unmapped accesses raise errors.

## Structure
- Shared package `rib_pkg`: `RIB_ADDR_W=32`, `RIB_DATA_W=32`, `RIB_SIDX_MSB=31`, `RIB_SIDX_LSB=28`, `RIB_ERR_CNT_W=8`.
- One sub-module `rib_rr_arb`: parametrised N-way round-robin arbiter with priority mask. It takes req, mask and ptr, and outputs a one-hot grant and an encoded index.

## Test plan
- **Round-robin:** masters 0 and 1 request continuously, PRIO_MASK=0 → grants alternate 0,1,0,1; `m_hold_o` alternates 2'b10/2'b01.
- **Priority class:** master 2 (prio) and masters 0,3 request → master 2 granted every cycle. When master 2 drops, 0 and 3 alternate starting from `rr_ptr=3`.
- **Decode/write:** master 0 writes 32'hDEADBEEF to 32'h1000_0010 → `s_we_o`=6'b000010, `s_addr_o`=32'h0000_0010.
- **Unmapped:** master 3 reads 32'h7000_0000 → `m_data_o`=0, `err_valid_o`=1, `err_master_o`=3, `err_cnt_o`=1. A second error leaves master/address unchanged with count=2.
- **ACL (RIB_ACL_EN):** ACL denies master 3 on slave 1; master 3 writes 32'h1000_0000 → no `s_we_o`, error recorded. Without the macro, the write strobes slave 1.
- **Clear, collision, reset:** `err_clr_i` with a simultaneous error → count=1 and new master captured. Asserting `rst` low mid-burst → error fields 0, `rr_ptr=0`.

Source files
------------

// File: rtl/rib_pkg.sv
// Shared constants for the RIB interconnect.
//   RIB_ADDR_W / RIB_DATA_W : bus address and data widths
//   RIB_SIDX_MSB/LSB        : address bits that select the slave
//   RIB_ERR_CNT_W           : width of the saturating error counter
package rib_pkg;

    localparam int unsigned RIB_ADDR_W    = 32;
    localparam int unsigned RIB_DATA_W    = 32;
    localparam int unsigned RIB_SIDX_MSB  = 31;
    localparam int unsigned RIB_SIDX_LSB  = 28;
    localparam int unsigned RIB_ERR_CNT_W = 8;

    localparam int unsigned RIB_SIDX_W = RIB_SIDX_MSB - RIB_SIDX_LSB + 1;

    localparam logic [RIB_ERR_CNT_W-1:0] RIB_ERR_CNT_MAX = '1;

endpackage

// File: rtl/rib_rr_arb.sv
// N-way round-robin arbiter with a priority class.
// If any requester is in mask, only masked requesters compete. Within the
// competing set the first requester at index >= ptr wins, wrapping modulo N.
// Ports:
//   req       in  N     : request vector
//   mask      in  N     : high-priority class
//   ptr       in  IDX_W : round-robin start index (0..N-1)
//   gnt       out N     : one-hot grant (all zero when nothing requests)
//   gnt_idx   out IDX_W : encoded grant index
//   gnt_valid out 1     : a grant was issued
module rib_rr_arb #(
    parameter  int unsigned N     = 6,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [N-1:0]     cand;
    logic [IDX_W-1:0] pos;
    int unsigned      k;

    always_comb begin
        cand      = (|(req & mask)) ? (req & mask) : req;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        k         = 0;
        pos       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr < N, so one subtraction is enough to wrap
            k = 32'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            pos = IDX_W'(k);
            if (!gnt_valid && cand[pos]) begin
                gnt[pos]  = 1'b1;
                gnt_idx   = pos;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rib_xbar.sv
// RIB crossbar: N masters arbitrated onto one single-cycle bus, M slaves
// decoded by addr[31:28], sticky error record for unmapped/denied accesses.
// Optional feature macro: RIB_ACL_EN enables the per-slave master access list.
// Ports:
//   clk, rst (async, active-low)
//   m_addr_i/m_data_i/m_we_i/m_req_i : per-master request
//   m_data_o                          : read data, broadcast to all masters
//   m_hold_o, hold_flag_o             : requesting but not granted / OR of it
//   s_addr_o/s_data_o/s_we_o          : slave-side address, wdata, one-hot strobe
//   s_data_i                          : per-slave read data
//   err_clr_i, err_valid_o, err_master_o, err_addr_o, err_cnt_o : error record
module rib_xbar
    import rib_pkg::*;
#(
    parameter int unsigned                        NUM_MASTERS = 6,
    parameter int unsigned                        NUM_SLAVES  = 6,
    parameter logic [NUM_MASTERS-1:0]             PRIO_MASK   = NUM_MASTERS'(6'b100100),
    parameter logic [NUM_SLAVES*NUM_MASTERS-1:0]  SLAVE_ACL   = '1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*RIB_ADDR_W-1:0] m_addr_i,
    input  logic [NUM_MASTERS*RIB_DATA_W-1:0] m_data_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    output logic [NUM_MASTERS*RIB_DATA_W-1:0] m_data_o,
    output logic [NUM_MASTERS-1:0]            m_hold_o,
    output logic                              hold_flag_o,
    output logic [RIB_ADDR_W-1:0]             s_addr_o,
    output logic [RIB_DATA_W-1:0]             s_data_o,
    output logic [NUM_SLAVES-1:0]             s_we_o,
    input  logic [NUM_SLAVES*RIB_DATA_W-1:0]  s_data_i,
    input  logic                              err_clr_i,
    output logic                              err_valid_o,
    output logic [3:0]                        err_master_o,
    output logic [RIB_ADDR_W-1:0]             err_addr_o,
    output logic [RIB_ERR_CNT_W-1:0]          err_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_valid;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [RIB_ADDR_W-1:0]  g_addr;
    logic [RIB_DATA_W-1:0]  g_data;
    logic                   g_we;
    logic [RIB_SIDX_W-1:0]  sidx;
    logic                   mapped;
    logic                   acl_bit;
    logic                   acl_ok;
    logic                   access_ok;
    logic                   err_hit;
    logic [RIB_DATA_W-1:0]  rd_data;
    logic [RIB_DATA_W-1:0]  bus_rdata;

    rib_rr_arb #(
        .N (NUM_MASTERS)
    ) u_arb (
        .req       (m_req_i),
        .mask      (PRIO_MASK),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_valid) begin
            rr_ptr_d = (32'(gnt_idx) == NUM_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Granted-master mux; everything stays zero when nothing is granted.
    always_comb begin
        g_addr = '0;
        g_data = '0;
        g_we   = 1'b0;
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            if (gnt[m]) begin
                g_addr = m_addr_i[m*RIB_ADDR_W +: RIB_ADDR_W];
                g_data = m_data_i[m*RIB_DATA_W +: RIB_DATA_W];
                g_we   = m_we_i[m];
            end
        end
    end

    always_comb begin
        sidx    = g_addr[RIB_SIDX_MSB:RIB_SIDX_LSB];
        mapped  = 32'(sidx) < NUM_SLAVES;
        rd_data = '0;
        acl_bit = 1'b0;
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            if (sidx == RIB_SIDX_W'(s)) begin
                rd_data = s_data_i[s*RIB_DATA_W +: RIB_DATA_W];
                for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
                    if (gnt[m]) begin
                        acl_bit = SLAVE_ACL[s*NUM_MASTERS+m];
                    end
                end
            end
        end
`ifdef RIB_ACL_EN
        acl_ok = acl_bit;
`else
        // Access list ignored in this build: every mapped access is allowed.
        acl_ok = acl_bit | 1'b1;
`endif
        access_ok = gnt_valid & mapped & acl_ok;
        err_hit   = gnt_valid & ~(mapped & acl_ok);
    end

    always_comb begin
        s_we_o = '0;
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            s_we_o[s] = access_ok & g_we & (sidx == RIB_SIDX_W'(s));
        end
        s_addr_o    = {4'h0, g_addr[RIB_SIDX_LSB-1:0]};
        s_data_o    = g_data;
        bus_rdata   = (access_ok & ~g_we) ? rd_data : '0;
        m_data_o    = {NUM_MASTERS{bus_rdata}};
        m_hold_o    = m_req_i & ~gnt;
        hold_flag_o = |m_hold_o;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q     <= '0;
            err_valid_o  <= 1'b0;
            err_master_o <= '0;
            err_addr_o   <= '0;
            err_cnt_o    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (err_clr_i) begin
                // A coincident error wins over the clear and starts a new record.
                err_valid_o  <= err_hit;
                err_master_o <= err_hit ? 4'(gnt_idx) : 4'h0;
                err_addr_o   <= err_hit ? g_addr : '0;
                err_cnt_o    <= err_hit ? RIB_ERR_CNT_W'(1) : '0;
            end else if (err_hit) begin
                if (!err_valid_o) begin
                    err_valid_o  <= 1'b1;
                    err_master_o <= 4'(gnt_idx);
                    err_addr_o   <= g_addr;
                end
                if (err_cnt_o != RIB_ERR_CNT_MAX) begin
                    err_cnt_o <= err_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rib_xbar.sv
module tb_rib_xbar;

    localparam int unsigned NM = 6;
    localparam int unsigned NS = 6;

    logic              clk;
    logic              rst;
    logic [NM*32-1:0]  m_addr_i;
    logic [NM*32-1:0]  m_data_i;
    logic [NM-1:0]     m_we_i;
    logic [NM-1:0]     m_req_i;
    logic [NM*32-1:0]  m_data_o;
    logic [NM-1:0]     m_hold_o;
    logic              hold_flag_o;
    logic [31:0]       s_addr_o;
    logic [31:0]       s_data_o;
    logic [NS-1:0]     s_we_o;
    logic [NS*32-1:0]  s_data_i;
    logic              err_clr_i;
    logic              err_valid_o;
    logic [3:0]        err_master_o;
    logic [31:0]       err_addr_o;
    logic [7:0]        err_cnt_o;

    int checks = 0;
    int errors = 0;

    // Slave 1 denies master 3 (bit 1*6+3 = 9 cleared).
    rib_xbar #(
        .NUM_MASTERS (NM),
        .NUM_SLAVES  (NS),
        .PRIO_MASK   (6'b100100),
        .SLAVE_ACL   (36'hF_FFFF_FDFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_addr_i     (m_addr_i),
        .m_data_i     (m_data_i),
        .m_we_i       (m_we_i),
        .m_req_i      (m_req_i),
        .m_data_o     (m_data_o),
        .m_hold_o     (m_hold_o),
        .hold_flag_o  (hold_flag_o),
        .s_addr_o     (s_addr_o),
        .s_data_o     (s_data_o),
        .s_we_o       (s_we_o),
        .s_data_i     (s_data_i),
        .err_clr_i    (err_clr_i),
        .err_valid_o  (err_valid_o),
        .err_master_o (err_master_o),
        .err_addr_o   (err_addr_o),
        .err_cnt_o    (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic we);
        m_addr_i[m*32 +: 32] = a;
        m_data_i[m*32 +: 32] = d;
        m_we_i[m]            = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        err_clr_i = 1'b0;
        m_req_i   = '0;
        m_we_i    = '0;
        m_data_i  = '0;
        for (int m = 0; m < NM; m++) set_m(m, 32'h2000_0000, 32'h0, 1'b0);
        for (int s = 0; s < NS; s++) s_data_i[s*32 +: 32] = 32'hA000_0000 + 32'(s);

        // Reset: record cleared, arbitration starts from index 0
        #1 rst = 1'b0;
        m_req_i = 6'b000011;
        #1;
        check("rst_err_valid", 64'(err_valid_o), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("rst_err_addr", 64'(err_addr_o), 64'd0);
        check("rst_hold", 64'(m_hold_o), 64'b000010);
        m_req_i = '0;
        @(negedge clk);
        rst = 1'b1;

        // Round-robin between masters 0 and 1
        step();
        m_req_i = 6'b000011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_hold", 64'(m_hold_o), (i % 2 == 0) ? 64'b000010 : 64'b000001);
        end
        check("rr_rdata", 64'(m_data_o[0 +: 32]), 64'hA000_0002);
        check("rr_rdata_bcast", 64'(m_data_o[5*32 +: 32]), 64'hA000_0002);

        // Priority class: master 2 wins over 0 and 3 (rr_ptr now 2)
        step();
        m_req_i = 6'b001101;
        @(negedge clk);
        check("prio_hold0", 64'(m_hold_o), 64'b001001);
        check("prio_flag", 64'(hold_flag_o), 64'd1);
        @(negedge clk);
        check("prio_hold1", 64'(m_hold_o), 64'b001001);
        step();
        m_req_i = 6'b001001;
        @(negedge clk);
        check("rr3_first", 64'(m_hold_o), 64'b000001);
        @(negedge clk);
        check("rr3_wrap0", 64'(m_hold_o), 64'b001000);
        @(negedge clk);
        check("rr3_back3", 64'(m_hold_o), 64'b000001);

        // Decode/write
        step();
        m_req_i = 6'b000001;
        set_m(0, 32'h1000_0010, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check("wr_we", 64'(s_we_o), 64'b000010);
        check("wr_addr", 64'(s_addr_o), 64'h0000_0010);
        check("wr_data", 64'(s_data_o), 64'hDEAD_BEEF);
        check("wr_flag", 64'(hold_flag_o), 64'd0);

        // Idle drives zero
        step();
        m_req_i = '0;
        set_m(0, 32'h2000_0000, 32'h0, 1'b0);
        @(negedge clk);
        check("idle_we", 64'(s_we_o), 64'd0);
        check("idle_addr", 64'(s_addr_o), 64'd0);
        check("idle_data", 64'(s_data_o), 64'd0);
        check("idle_rdata", 64'(m_data_o[0 +: 32]), 64'd0);
        check("idle_err", 64'(err_valid_o), 64'd0);

        // Unmapped read by master 3, then a second error by master 1
        step();
        m_req_i = 6'b001000;
        set_m(3, 32'h7000_0000, 32'h0, 1'b0);
        @(negedge clk);
        check("unm_rdata", 64'(m_data_o[3*32 +: 32]), 64'd0);
        check("unm_we", 64'(s_we_o), 64'd0);
        step();
        m_req_i = 6'b000010;
        set_m(1, 32'hF000_0004, 32'h0, 1'b0);
        @(negedge clk);
        check("unm_valid", 64'(err_valid_o), 64'd1);
        check("unm_master", 64'(err_master_o), 64'd3);
        check("unm_addr", 64'(err_addr_o), 64'h7000_0000);
        check("unm_cnt1", 64'(err_cnt_o), 64'd1);
        step();
        m_req_i = '0;
        set_m(1, 32'h2000_0000, 32'h0, 1'b0);
        @(negedge clk);
        check("unm2_master", 64'(err_master_o), 64'd3);
        check("unm2_addr", 64'(err_addr_o), 64'h7000_0000);
        check("unm2_cnt", 64'(err_cnt_o), 64'd2);

        // Access list: master 3 writes slave 1
        step();
        m_req_i = 6'b001000;
        set_m(3, 32'h1000_0000, 32'h1234_5678, 1'b1);
        @(negedge clk);
`ifdef RIB_ACL_EN
        check("acl_we", 64'(s_we_o), 64'd0);
`else
        check("acl_we", 64'(s_we_o), 64'b000010);
`endif
        step();
        m_req_i = '0;
        set_m(3, 32'h2000_0000, 32'h0, 1'b0);
        @(negedge clk);
`ifdef RIB_ACL_EN
        check("acl_cnt", 64'(err_cnt_o), 64'd3);
`else
        check("acl_cnt", 64'(err_cnt_o), 64'd2);
`endif

        // Clear coinciding with a new error from master 5
        step();
        err_clr_i = 1'b1;
        m_req_i   = 6'b100000;
        set_m(5, 32'h9000_0000, 32'h0, 1'b0);
        step();
        err_clr_i = 1'b0;
        m_req_i   = '0;
        @(negedge clk);
        check("clr_valid", 64'(err_valid_o), 64'd1);
        check("clr_master", 64'(err_master_o), 64'd5);
        check("clr_addr", 64'(err_addr_o), 64'h9000_0000);
        check("clr_cnt", 64'(err_cnt_o), 64'd1);

        // Plain clear
        step();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        @(negedge clk);
        check("clr2_valid", 64'(err_valid_o), 64'd0);
        check("clr2_master", 64'(err_master_o), 64'd0);
        check("clr2_addr", 64'(err_addr_o), 64'd0);
        check("clr2_cnt", 64'(err_cnt_o), 64'd0);

        // Counter saturation: 260 consecutive errors
        step();
        m_req_i = 6'b100000;
        repeat (260) @(posedge clk);
        #1;
        m_req_i = '0;
        @(negedge clk);
        check("sat_cnt", 64'(err_cnt_o), 64'd255);

        // Reset mid-burst: rr_ptr is 1 after master 0's grant, reset returns it to 0
        step();
        m_req_i = 6'b000001;
        step();
        m_req_i = 6'b000011;
        rst     = 1'b0;
        #1;
        check("rst2_hold", 64'(m_hold_o), 64'b000010);
        check("rst2_valid", 64'(err_valid_o), 64'd0);
        check("rst2_cnt", 64'(err_cnt_o), 64'd0);
        check("rst2_master", 64'(err_master_o), 64'd0);
        check("rst2_addr", 64'(err_addr_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_rr", 64'(m_hold_o), 64'b000001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
